// File: rtl/mont_final_sub.sv
// Final conditional subtraction for Montgomery multiplication: computes t - M
// chunk-serially and returns t - M when it does not borrow, otherwise t.
module mont_final_sub #(
  parameter int T_W   = 1028,
  parameter int M_W   = 1024,
  parameter int CHUNK = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [T_W-1:0] in_t,
  input  logic [M_W-1:0] in_m,
  output logic           busy,
  output logic           done,
  output logic [M_W-1:0] result,
  output logic           out_of_range
);

  localparam int NCHUNK = (T_W + CHUNK - 1) / CHUNK;
  localparam int PAD_W  = NCHUNK * CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, SUB, SEL} state_t;

  state_t           state;
  logic [PAD_W-1:0] tsh;
  logic [PAD_W-1:0] msh;
  logic [PAD_W-1:0] dsh;
  logic [M_W-1:0]   thold;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic [CHUNK:0]   sub_full;

  // Top bit of the widened difference is the borrow out of this chunk.
  assign sub_full = {1'b0, tsh[CHUNK-1:0]} - {1'b0, msh[CHUNK-1:0]}
                  - {{CHUNK{1'b0}}, borrow};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      out_of_range <= 1'b0;
      cnt          <= '0;
      borrow       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tsh    <= PAD_W'(in_t);
            thold  <= in_t[M_W-1:0];
            msh    <= PAD_W'(in_m);
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SUB;
          end
        end
        SUB: begin
          borrow <= sub_full[CHUNK];
          dsh    <= {sub_full[CHUNK-1:0], dsh[PAD_W-1:CHUNK]};
          tsh    <= tsh >> CHUNK;
          msh    <= msh >> CHUNK;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= SEL;
        end
        SEL: begin
          result <= borrow ? thold : dsh[M_W-1:0];
          // Without a final borrow the padded difference is exact, so any set
          // bit above M_W means t - M does not fit the result width.
          out_of_range <= ~borrow & (|dsh[PAD_W-1:M_W]);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_final_sub.sv
// Directed bench for mont_final_sub: latency, borrow paths, range flag,
// start-while-busy, back-to-back start and mid-operation reset.
module tb_mont_final_sub;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1027:0] in_t;
  logic [1023:0] in_m;
  logic          busy;
  logic          done;
  logic [1023:0] result;
  logic          out_of_range;

  int errors = 0;
  int checks = 0;

  mont_final_sub dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_t         (in_t),
    .in_m         (in_m),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .out_of_range (out_of_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got low128=%h expected low128=%h", tag, got[127:0], exp[127:0]);
    end else begin
      $display("ok   %s: low128=%h", tag, got[127:0]);
    end
  endtask

  // Issue one request and wait (bounded) for done; lat = edges after accept.
  task automatic do_op(input logic [1027:0] t, input logic [1023:0] m, output int lat);
    in_t  = t;
    in_m  = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_accept", 1024'(busy), 1024'(1));
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  logic [1023:0] mod_a;
  logic [1023:0] ones;
  logic [1023:0] exp_v;
  int lat;
  int ndone;

  initial begin
    mod_a = {1'b1, 1022'b0, 1'b1};
    ones  = '1;
    reset = 1'b1;
    start = 1'b0;
    in_t  = '0;
    in_m  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", 1024'(busy), 1024'(0));
    check("reset_done", 1024'(done), 1024'(0));
    check("reset_result", result, 1024'(0));
    check("reset_oor", 1024'(out_of_range), 1024'(0));

    // t = M + 5 -> 5
    do_op({4'b0, mod_a} + 1028'd5, mod_a, lat);
    check("lat_m_plus5", 1024'(lat), 1024'(10));
    check("res_m_plus5", result, 1024'(5));
    check("oor_m_plus5", 1024'(out_of_range), 1024'(0));
    @(posedge clk);
    #1;
    check("done_one_cycle", 1024'(done), 1024'(0));
    check("busy_after_done", 1024'(busy), 1024'(0));
    check("res_held", result, 1024'(5));

    // t = M - 1 -> borrow path returns t
    exp_v = mod_a - 1024'd1;
    do_op({4'b0, mod_a} - 1028'd1, mod_a, lat);
    check("lat_m_minus1", 1024'(lat), 1024'(10));
    check("res_m_minus1", result, exp_v);
    check("oor_m_minus1", 1024'(out_of_range), 1024'(0));

    // t = M -> 0
    do_op({4'b0, mod_a}, mod_a, lat);
    check("res_t_eq_m", result, 1024'(0));

    // borrow ripples through every chunk
    do_op(1028'd1 << 1024, 1024'd1, lat);
    check("res_ripple", result, ones);
    check("oor_ripple", 1024'(out_of_range), 1024'(0));

    // t >= 2M contract violation
    exp_v = ones - 1024'd2;
    do_op(1028'd1 << 1027, 1024'd3, lat);
    check("res_violation", result, exp_v);
    check("oor_violation", 1024'(out_of_range), 1024'(1));

    // M = 0: result is low bits of t, flag from top nibble
    do_op((1028'd1 << 1027) + 1028'd7, 1024'd0, lat);
    check("res_m_zero", result, 1024'(7));
    check("oor_m_zero", 1024'(out_of_range), 1024'(1));

    // second start while busy is dropped; start in done cycle is accepted
    in_t  = {4'b0, mod_a} + 1028'd5;
    in_m  = mod_a;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) begin
        start = 1'b1;
        in_t  = {4'b0, mod_a} + 1028'd9;
      end
      if (n == 4) start = 1'b0;
      if (done) begin
        ndone++;
        lat = n;
      end
    end
    check("busy_start_ndone", 1024'(ndone), 1024'(1));
    check("busy_start_lat", 1024'(lat), 1024'(10));
    check("busy_start_res", result, 1024'(5));
    in_t  = {4'b0, mod_a} + 1028'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    lat = 0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        lat = n;
      end
    end
    check("b2b_ndone", 1024'(ndone), 1024'(1));
    check("b2b_lat", 1024'(lat), 1024'(10));
    check("b2b_res", result, 1024'(7));

    // reset in the middle of an operation
    in_t  = {4'b0, mod_a} + 1028'd5;
    in_m  = mod_a;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_busy", 1024'(busy), 1024'(0));
    check("abort_done", 1024'(done), 1024'(0));
    check("abort_result", result, 1024'(0));
    ndone = 0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort_no_done", 1024'(ndone), 1024'(0));
    do_op({4'b0, mod_a} + 1028'd11, mod_a, lat);
    check("after_abort_lat", 1024'(lat), 1024'(10));
    check("after_abort_res", result, 1024'(11));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
